// File: rtl/cdma_arb_pkg.sv
// cdma_arb_pkg: shared widths, ID-width helper and the command type
package cdma_arb_pkg;
  localparam int AXI_ADDR_BITS = 32;
  localparam int CDMA_LEN_BITS = 32;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic [AXI_ADDR_BITS-1:0] paddr;
    logic [CDMA_LEN_BITS-1:0] len;
  } cdma_cmd_t;
endpackage

// File: rtl/cdma_arb_if.sv
// cdma_arb_if: one command direction, requester side plus CDMA side
interface cdma_arb_if import cdma_arb_pkg::*; #(
  parameter int N_REQ     = 4,
  parameter int ADDR_BITS = AXI_ADDR_BITS,
  parameter int LEN_BITS  = CDMA_LEN_BITS
);
  logic [N_REQ-1:0]           s_valid;
  logic [N_REQ-1:0]           s_ready;
  logic [N_REQ*ADDR_BITS-1:0] s_paddr;
  logic [N_REQ*LEN_BITS-1:0]  s_len;
  logic [N_REQ-1:0]           s_done;
  logic                       m_valid;
  logic                       m_ready;
  logic [ADDR_BITS-1:0]       m_paddr;
  logic [LEN_BITS-1:0]        m_len;
  logic                       m_done;
  logic                       err;
  modport slave (
    input  s_valid, s_paddr, s_len, m_ready, m_done,
    output s_ready, s_done, m_valid, m_paddr, m_len, err
  );
  modport master (
    output s_valid, s_paddr, s_len, m_ready, m_done,
    input  s_ready, s_done, m_valid, m_paddr, m_len, err
  );
endinterface

// File: rtl/cdma_arb_ch.sv
// cdma_arb_ch: one direction - round-robin arbiter, output register, in-order ID queue, sticky error
module cdma_arb_ch import cdma_arb_pkg::*; #(
  parameter int N_REQ     = 4,
  parameter int ADDR_BITS = AXI_ADDR_BITS,
  parameter int LEN_BITS  = CDMA_LEN_BITS,
  parameter int MAX_OUT   = 16
) (
  input logic       aclk,
  input logic       aresetn,
  cdma_arb_if.slave ch
);
  localparam int IDW = idw(N_REQ);
  localparam int QW  = $clog2(MAX_OUT);
  typedef struct packed {
    logic [ADDR_BITS-1:0] paddr;
    logic [LEN_BITS-1:0]  len;
  } cmd_t;
  cmd_t           cmd;
  logic [IDW-1:0] ptr, gnt;
  logic [IDW:0]   j;
  logic [IDW-1:0] q [MAX_OUT];
  logic [QW-1:0]  head, tail;
  logic [QW:0]    cnt;
  logic           found, take, pop;
  // Scan from the requester after the last grantee; grant only when a slot and the output register are free
  always_comb begin
    found = 1'b0;
    gnt   = ptr;
    j     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = {1'b0, ptr} + (IDW+1)'(k);
      j = (j >= (IDW+1)'(N_REQ)) ? j - (IDW+1)'(N_REQ) : j;
      if (!found && ch.s_valid[j[IDW-1:0]]) begin
        found = 1'b1;
        gnt   = j[IDW-1:0];
      end
    end
    take       = aresetn && found && (!ch.m_valid || ch.m_ready) && (cnt < (QW+1)'(MAX_OUT));
    pop        = ch.m_done && (cnt != '0);
    ch.s_ready = take ? N_REQ'(1) << gnt : '0;
  end
  // Output register, RR pointer, queue pointers/count, done steering and sticky error
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ch.m_valid <= 1'b0;
      cmd        <= '0;
      ptr        <= IDW'(N_REQ-1);
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      ch.s_done  <= '0;
      ch.err     <= 1'b0;
    end else begin
      if (take) begin
        ch.m_valid <= 1'b1;
        cmd        <= {ch.s_paddr[gnt*ADDR_BITS +: ADDR_BITS], ch.s_len[gnt*LEN_BITS +: LEN_BITS]};
        tail       <= tail + QW'(1);
        ptr        <= gnt;
      end else if (ch.m_ready) begin
        ch.m_valid <= 1'b0;
      end
      head      <= head + QW'(pop);
      cnt       <= cnt + (QW+1)'(take) - (QW+1)'(pop);
      ch.s_done <= pop ? N_REQ'(1) << q[head] : '0;
      ch.err    <= ch.err | (ch.m_done & ~pop);
    end
  end
  // Grantee IDs in issue order; stale entries are simply overwritten
  always_ff @(posedge aclk) begin
    if (take) q[tail] <= gnt;
  end
  assign ch.m_paddr = cmd.paddr;
  assign ch.m_len   = cmd.len;
endmodule

// File: rtl/cdma_arb.sv
// cdma_arb: shares one CDMA engine between N_REQ requesters with independent rd/wr arbitration
module cdma_arb import cdma_arb_pkg::*; #(
  parameter int N_REQ     = 4,
  parameter int ADDR_BITS = AXI_ADDR_BITS,
  parameter int LEN_BITS  = CDMA_LEN_BITS,
  parameter int MAX_OUT   = 16
) (
  input logic       aclk,
  input logic       aresetn,
  cdma_arb_if.slave rd,
  cdma_arb_if.slave wr
);
  cdma_arb_ch #(.N_REQ(N_REQ), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .MAX_OUT(MAX_OUT)) u_rd (
    .aclk(aclk), .aresetn(aresetn), .ch(rd)
  );
  cdma_arb_ch #(.N_REQ(N_REQ), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .MAX_OUT(MAX_OUT)) u_wr (
    .aclk(aclk), .aresetn(aresetn), .ch(wr)
  );
endmodule

// File: tb/tb_cdma_arb.sv
// tb_cdma_arb: directed scenarios plus randomized traffic against a queue-based model
module tb_cdma_arb;
  import cdma_arb_pkg::*;
  localparam int N  = 4;
  localparam int AW = AXI_ADDR_BITS;
  localparam int LW = CDMA_LEN_BITS;
  localparam int MO = 16;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int checks = 0;
  int errors = 0;
  cdma_arb_if #(.N_REQ(N), .ADDR_BITS(AW), .LEN_BITS(LW)) rd_if ();
  cdma_arb_if #(.N_REQ(N), .ADDR_BITS(AW), .LEN_BITS(LW)) wr_if ();
  cdma_arb #(.N_REQ(N), .ADDR_BITS(AW), .LEN_BITS(LW), .MAX_OUT(MO)) dut (
    .aclk(aclk), .aresetn(aresetn), .rd(rd_if), .wr(wr_if)
  );
  always #5 aclk = ~aclk;
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++; if ({rd_if.s_ready, rd_if.s_done, rd_if.m_valid, rd_if.err} !== '0) begin errors++; $display("FAIL reset_rd_ctl got ready=%b done=%b valid=%b err=%b want 0", rd_if.s_ready, rd_if.s_done, rd_if.m_valid, rd_if.err); end
    checks++; if ({rd_if.m_paddr, rd_if.m_len} !== '0) begin errors++; $display("FAIL reset_rd_data got paddr=%h len=%h want 0", rd_if.m_paddr, rd_if.m_len); end
    checks++; if ({wr_if.s_ready, wr_if.s_done, wr_if.m_valid, wr_if.err} !== '0) begin errors++; $display("FAIL reset_wr_ctl got ready=%b done=%b valid=%b err=%b want 0", wr_if.s_ready, wr_if.s_done, wr_if.m_valid, wr_if.err); end
    checks++; if ({wr_if.m_paddr, wr_if.m_len} !== '0) begin errors++; $display("FAIL reset_wr_data got paddr=%h len=%h want 0", wr_if.m_paddr, wr_if.m_len); end
    aresetn = 1'b1;
    tick();
  endtask
  task automatic test_single_rd();
    rd_if.m_ready = 1'b1;
    rd_if.s_valid = 4'b0100;
    rd_if.s_paddr[2*AW +: AW] = AW'('h1000);
    rd_if.s_len[2*LW +: LW] = LW'(64);
    #1;
    checks++; if (rd_if.s_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", rd_if.s_ready); end
    tick();
    rd_if.s_valid = '0;
    checks++; if (rd_if.m_valid !== 1'b1 || rd_if.m_paddr !== AW'('h1000) || rd_if.m_len !== LW'(64)) begin errors++; $display("FAIL single_cmd got v=%b paddr=%h len=%0d want v=1 paddr=1000 len=64", rd_if.m_valid, rd_if.m_paddr, rd_if.m_len); end
    tick();
    checks++; if (rd_if.m_valid !== 1'b0) begin errors++; $display("FAIL single_drain got v=%b want 0", rd_if.m_valid); end
    rd_if.m_done = 1'b1;
    tick();
    rd_if.m_done = 1'b0;
    checks++; if (rd_if.s_done !== 4'b0100) begin errors++; $display("FAIL single_done got %b want 0100", rd_if.s_done); end
    tick();
    checks++; if (rd_if.s_done !== 4'b0000) begin errors++; $display("FAIL single_done_once got %b want 0000", rd_if.s_done); end
  endtask
  task automatic test_rr_wr();
    int ptr;
    int e;
    int ids[$];
    ptr = N - 1;
    for (int i = 0; i < N; i++) begin
      wr_if.s_paddr[i*AW +: AW] = AW'('h2000 + i * 'h100);
      wr_if.s_len[i*LW +: LW] = LW'(16 * (i + 1));
    end
    wr_if.m_ready = 1'b1;
    wr_if.s_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      e = (ptr + 1) % N;
      checks++; if (wr_if.s_ready !== N'(1 << e)) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", c, wr_if.s_ready, N'(1 << e)); end
      ids.push_back(e);
      ptr = e;
      tick();
      checks++; if (wr_if.m_valid !== 1'b1 || wr_if.m_paddr !== AW'('h2000 + e * 'h100) || wr_if.m_len !== LW'(16 * (e + 1))) begin errors++; $display("FAIL rr_cmd[%0d] got v=%b paddr=%h len=%0d want requester %0d", c, wr_if.m_valid, wr_if.m_paddr, wr_if.m_len, e); end
    end
    wr_if.s_valid = '0;
    tick();
    wr_if.m_done = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 7) wr_if.m_done = 1'b0;
      e = ids.pop_front();
      checks++; if (wr_if.s_done !== N'(1 << e)) begin errors++; $display("FAIL rr_done[%0d] got %b want %b", c, wr_if.s_done, N'(1 << e)); end
    end
    tick();
    checks++; if (wr_if.s_done !== '0 || wr_if.err !== 1'b0) begin errors++; $display("FAIL rr_done_end got done=%b err=%b want 0 0", wr_if.s_done, wr_if.err); end
  endtask
  task automatic test_stall_rd();
    for (int i = 0; i < N; i++) begin
      rd_if.s_paddr[i*AW +: AW] = AW'('h3000 + i * 'h10);
      rd_if.s_len[i*LW +: LW] = LW'(i + 1);
    end
    rd_if.m_ready = 1'b0;
    rd_if.s_valid = '1;
    #1;
    checks++; if (rd_if.s_ready !== 4'b1000) begin errors++; $display("FAIL stall_first got %b want 1000", rd_if.s_ready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rd_if.s_ready !== '0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", c, rd_if.s_ready); end
      tick();
      checks++; if (rd_if.m_valid !== 1'b1 || rd_if.m_paddr !== AW'('h3030)) begin errors++; $display("FAIL stall_hold[%0d] got v=%b paddr=%h want v=1 paddr=3030", c, rd_if.m_valid, rd_if.m_paddr); end
    end
    rd_if.m_ready = 1'b1;
    #1;
    checks++; if (rd_if.s_ready !== 4'b0001) begin errors++; $display("FAIL stall_release got %b want 0001", rd_if.s_ready); end
    tick();
    rd_if.s_valid = '0;
    checks++; if (rd_if.m_valid !== 1'b1 || rd_if.m_paddr !== AW'('h3000)) begin errors++; $display("FAIL stall_next got v=%b paddr=%h want v=1 paddr=3000", rd_if.m_valid, rd_if.m_paddr); end
    tick();
    rd_if.m_done = 1'b1;
    tick();
    checks++; if (rd_if.s_done !== 4'b1000) begin errors++; $display("FAIL stall_done0 got %b want 1000", rd_if.s_done); end
    tick();
    rd_if.m_done = 1'b0;
    checks++; if (rd_if.s_done !== 4'b0001) begin errors++; $display("FAIL stall_done1 got %b want 0001", rd_if.s_done); end
  endtask
  task automatic test_max_out();
    rd_if.m_ready = 1'b1;
    rd_if.s_paddr[1*AW +: AW] = AW'('h4000);
    rd_if.s_valid = 4'b0010;
    for (int c = 0; c < MO; c++) begin
      #1;
      checks++; if (rd_if.s_ready !== 4'b0010) begin errors++; $display("FAIL max_fill[%0d] got %b want 0010", c, rd_if.s_ready); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rd_if.s_ready !== '0) begin errors++; $display("FAIL max_full[%0d] got %b want 0000", c, rd_if.s_ready); end
      tick();
    end
    rd_if.m_done = 1'b1;
    #1;
    checks++; if (rd_if.s_ready !== '0) begin errors++; $display("FAIL max_same_cycle got %b want 0000", rd_if.s_ready); end
    tick();
    rd_if.m_done = 1'b0;
    checks++; if (rd_if.s_done !== 4'b0010) begin errors++; $display("FAIL max_pop_done got %b want 0010", rd_if.s_done); end
    #1;
    checks++; if (rd_if.s_ready !== 4'b0010) begin errors++; $display("FAIL max_regrant got %b want 0010", rd_if.s_ready); end
    tick();
    rd_if.s_valid = '0;
    rd_if.m_done = 1'b1;
    for (int c = 0; c < MO; c++) begin
      tick();
      if (c == MO - 1) rd_if.m_done = 1'b0;
      checks++; if (rd_if.s_done !== 4'b0010) begin errors++; $display("FAIL max_drain[%0d] got %b want 0010", c, rd_if.s_done); end
    end
    tick();
    checks++; if (rd_if.s_done !== '0 || rd_if.err !== 1'b0) begin errors++; $display("FAIL max_end got done=%b err=%b want 0 0", rd_if.s_done, rd_if.err); end
  endtask
  task automatic test_err_wr();
    rd_if.s_paddr[0 +: AW] = AW'('h5000);
    rd_if.s_valid = 4'b0001;
    wr_if.m_done = 1'b1;
    #1;
    checks++; if (rd_if.s_ready !== 4'b0001) begin errors++; $display("FAIL err_rd_ready got %b want 0001", rd_if.s_ready); end
    tick();
    rd_if.s_valid = '0;
    wr_if.m_done = 1'b0;
    checks++; if (wr_if.err !== 1'b1 || wr_if.s_done !== '0) begin errors++; $display("FAIL err_set got err=%b done=%b want 1 0000", wr_if.err, wr_if.s_done); end
    checks++; if (rd_if.m_valid !== 1'b1 || rd_if.m_paddr !== AW'('h5000) || rd_if.err !== 1'b0) begin errors++; $display("FAIL err_rd_cmd got v=%b paddr=%h err=%b want 1 5000 0", rd_if.m_valid, rd_if.m_paddr, rd_if.err); end
    rd_if.m_done = 1'b1;
    tick();
    rd_if.m_done = 1'b0;
    checks++; if (rd_if.s_done !== 4'b0001 || wr_if.s_done !== '0) begin errors++; $display("FAIL err_rd_done got rd=%b wr=%b want 0001 0000", rd_if.s_done, wr_if.s_done); end
    repeat (3) tick();
    checks++; if (wr_if.err !== 1'b1 || rd_if.err !== 1'b0) begin errors++; $display("FAIL err_sticky got wr=%b rd=%b want 1 0", wr_if.err, rd_if.err); end
  endtask
  task automatic test_reset_mid();
    rd_if.m_ready = 1'b1;
    rd_if.s_valid = '1;
    repeat (5) tick();
    rd_if.s_valid = '0;
    aresetn = 1'b0;
    tick();
    checks++; if ({rd_if.s_ready, rd_if.s_done, rd_if.m_valid, rd_if.err, rd_if.m_paddr, rd_if.m_len} !== '0) begin errors++; $display("FAIL mid_reset_rd got v=%b done=%b err=%b paddr=%h want 0", rd_if.m_valid, rd_if.s_done, rd_if.err, rd_if.m_paddr); end
    checks++; if ({wr_if.s_ready, wr_if.s_done, wr_if.m_valid, wr_if.err} !== '0) begin errors++; $display("FAIL mid_reset_wr got v=%b done=%b err=%b want 0", wr_if.m_valid, wr_if.s_done, wr_if.err); end
    aresetn = 1'b1;
    tick();
    rd_if.s_paddr[2*AW +: AW] = AW'('h6000);
    rd_if.s_valid = 4'b0110;
    #1;
    checks++; if (rd_if.s_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr got %b want 0010", rd_if.s_ready); end
    rd_if.s_valid = 4'b0100;
    #1;
    checks++; if (rd_if.s_ready !== 4'b0100) begin errors++; $display("FAIL mid_ready got %b want 0100", rd_if.s_ready); end
    tick();
    rd_if.s_valid = '0;
    checks++; if (rd_if.m_paddr !== AW'('h6000)) begin errors++; $display("FAIL mid_cmd got %h want 6000", rd_if.m_paddr); end
    rd_if.m_done = 1'b1;
    tick();
    rd_if.m_done = 1'b0;
    checks++; if (rd_if.s_done !== 4'b0100) begin errors++; $display("FAIL mid_done got %b want 0100", rd_if.s_done); end
    rd_if.m_done = 1'b1;
    tick();
    rd_if.m_done = 1'b0;
    checks++; if (rd_if.err !== 1'b1 || rd_if.s_done !== '0) begin errors++; $display("FAIL mid_dropped got err=%b done=%b want 1 0000", rd_if.err, rd_if.s_done); end
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
  endtask
  task automatic test_random();
    bit out_full;
    cdma_cmd_t out_cmd;
    int ptr;
    int win;
    int q[$];
    logic [N-1:0] exp_done;
    logic [N-1:0] exp_ready;
    out_full = 1'b0;
    out_cmd = '0;
    ptr = N - 1;
    for (int c = 0; c < 400; c++) begin
      rd_if.s_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        rd_if.s_paddr[i*AW +: AW] = AW'($urandom);
        rd_if.s_len[i*LW +: LW] = LW'($urandom);
      end
      rd_if.m_ready = ($urandom_range(0, 3) != 0);
      rd_if.m_done = (q.size() > 0) && ($urandom_range(0, (c < 200) ? 7 : 1) == 0);
      #1;
      win = -1;
      if ((!out_full || rd_if.m_ready) && q.size() < MO)
        for (int k = 1; k <= N; k++)
          if (win < 0 && rd_if.s_valid[(ptr + k) % N]) win = (ptr + k) % N;
      exp_ready = (win >= 0) ? N'(1 << win) : '0;
      checks++; if (rd_if.s_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, rd_if.s_ready, exp_ready); end
      exp_done = (rd_if.m_done && q.size() > 0) ? N'(1 << q.pop_front()) : '0;
      if (win >= 0) begin
        out_full = 1'b1;
        out_cmd.paddr = rd_if.s_paddr[win*AW +: AW];
        out_cmd.len = rd_if.s_len[win*LW +: LW];
        q.push_back(win);
        ptr = win;
      end else if (rd_if.m_ready) begin
        out_full = 1'b0;
      end
      tick();
      checks++; if (rd_if.m_valid !== out_full || rd_if.s_done !== exp_done) begin errors++; $display("FAIL rand_out[%0d] got v=%b done=%b want v=%b done=%b", c, rd_if.m_valid, rd_if.s_done, out_full, exp_done); end
      if (out_full) begin
        checks++; if ({rd_if.m_paddr, rd_if.m_len} !== out_cmd) begin errors++; $display("FAIL rand_cmd[%0d] got %h/%h want %h/%h", c, rd_if.m_paddr, rd_if.m_len, out_cmd.paddr, out_cmd.len); end
      end
    end
    rd_if.s_valid = '0;
    rd_if.m_done = 1'b0;
    checks++; if (rd_if.err !== 1'b0) begin errors++; $display("FAIL rand_err got %b want 0", rd_if.err); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rd_if.s_valid = '0; rd_if.s_paddr = '0; rd_if.s_len = '0; rd_if.m_ready = 1'b0; rd_if.m_done = 1'b0;
    wr_if.s_valid = '0; wr_if.s_paddr = '0; wr_if.s_len = '0; wr_if.m_ready = 1'b0; wr_if.m_done = 1'b0;
    test_reset();
    test_single_rd();
    test_rr_wr();
    test_stall_rd();
    test_max_out();
    test_err_wr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdma_arb.md
# cdma_arb

Command arbiter that shares one aligned CDMA engine between N_REQ requesters. Read and write command channels are arbitrated independently with round-robin fairness. Each grant is forwarded to the CDMA rd/wr command port, and the grantee ID is recorded in an in-order outstanding queue. Every CDMA done pulse is steered back to the requester that issued the matching command. Sits between the MLO layer sequencers and the CDMA command inputs.

## Interface
- N_REQ, 4: number of requesters, 2..16
- ADDR_BITS, AXI_ADDR_BITS: physical address width
- LEN_BITS, 32: transfer length width (bytes)
- MAX_OUT, 16: outstanding commands tracked per direction, power of two, ≥2
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- s_rd_valid / s_rd_ready  in/out  N_REQ  per-requester read command handshake
- s_rd_paddr  in  N_REQ*ADDR_BITS  read address; requester i at slice i
- s_rd_len  in  N_REQ*LEN_BITS  read length
- s_rd_done  out  N_REQ  one-cycle completion pulse to the issuing requester
- s_wr_valid, s_wr_ready, s_wr_paddr, s_wr_len, s_wr_done: write-side equivalents, same widths
- m_rd_valid / m_rd_ready  out/in  1  command handshake to the CDMA read port
- m_rd_paddr  out  ADDR_BITS; m_rd_len  out  LEN_BITS
- m_rd_done  in  1  CDMA read completion pulse; completions arrive in issue order
- m_wr_valid, m_wr_ready, m_wr_paddr, m_wr_len, m_wr_done: write-side equivalents
- rd_err, wr_err  out  1  sticky flag: a done arrived with the outstanding queue empty

## Operation
- The two directions are identical and independent; each has its own arbiter, output register, ID queue and RR pointer.
- Arbitration:
  - The arbiter is eligible when the output register is empty (or is being emptied this cycle by m_*_ready) and the queue count < MAX_OUT.
  - When eligible, scan requesters starting at ptr+1 mod N_REQ and pick the first i with s_valid[i]=1.
  - Assert s_ready[i] only for the chosen i, and only in that cycle. Load paddr/len into the output register, push i into the ID queue, and set ptr←i.
- Output register: m_valid is held with stable data until m_ready. Back-to-back issue is allowed, so the sustained rate is one command per cycle.
- Completion:
  - m_done=1 with the queue non-empty pops the head h; s_done[h] pulses on the next cycle.
  - m_done with the queue empty: no pop, no s_done pulse, and err is set to 1 until reset.
- Queue count rules:
  - Push and pop in the same cycle leave the count unchanged.
  - The eligibility check uses the registered count, so a pop does not free a slot for a push in the same cycle.
- ID width is IDW=$clog2(N_REQ), minimum 1.

## Timing
- Reset values: all s_*_ready=0, s_*_done=0, m_*_valid=0, m_*_paddr/len=0, *_err=0, ptr=N_REQ-1 (so requester 0 wins first), queue empty.
- Latency from s_valid/s_ready acceptance to m_valid is 1 cycle.
- Latency from m_done to s_done is 1 cycle.
- s_ready is combinational from s_valid, the count and the output-register state. There is no combinational path from m_ready to m_valid.
- Reset asserted mid-operation: the queue, output register and pointers clear on the next edge. Outstanding completions are dropped.

## Structure
- Add cdma_arb_pkg with:
  - localparam helper for IDW
  - typedef cdma_cmd_t {paddr, len}
- Sub-module cdma_arb_ch holds one direction (RR arbiter, output register, ID queue, err flag). It is instantiated twice. Its ID queue is an inline circular buffer of MAX_OUT×IDW with wrapping head/tail pointers.

## Test plan
- Reset, then single requester 2 issues rd {0x1000, 64} → m_rd_valid 1 cycle later carrying that data. A later m_rd_done → s_rd_done[2] pulses once, 1 cycle after.
- All 4 requesters hold wr_valid with m_wr_ready=1 → grant order 0,1,2,3,0,… with one grant per cycle. s_wr_done pulses follow issue order for an in-order done stream.
- Hold m_rd_ready=0 → exactly one command is accepted and the others stall. m_rd_paddr stays stable until ready.
- MAX_OUT=16, no m_rd_done → 16 issues, then s_rd_ready stays 0. One m_rd_done → the next grant occurs 1 cycle later, not in the same cycle.
- m_wr_done with an empty queue → wr_err=1 and stays high, with no s_wr_done pulse. Concurrent rd traffic is unaffected.
- Assert aresetn=0 with 5 commands outstanding → after reset all outputs are at reset values, and a new command routes its done correctly.
